seq_divider_32bit: RTL and testbench
====================================

# seq_divider_32bit

Multi-cycle restoring divider: the subtract-direction counterpart to the team's ripple/carry-select adders. It computes quotient and remainder of two WIDTH-bit operands with one trial subtraction per clock. It sits beside the SimpleALU as a long-latency functional unit, driven by a start/done handshake, so the single-cycle ALU datapath never contains a divider.

## Interface
- WIDTH, 32, operand/result width in bits (≥ 2)
- clock  input  1  rising-edge clock
- reset_n  input  1  asynchronous, active-low reset
- start  input  1  request; sampled only when not busy
- dividend  input  WIDTH  numerator, latched on accepted start
- divisor  input  WIDTH  denominator, latched on accepted start
- busy  output  1  high while an operation is in flight
- done  output  1  single-cycle pulse: results valid
- quotient  output  WIDTH  result quotient
- remainder  output  WIDTH  result remainder
- div_by_zero  output  1  divisor was zero for the latest completed operation

## Operation
- FSM states: IDLE, RUN, DONE. Reset → IDLE.
- IDLE/DONE + start=1: latch operands, clear partial remainder, load iteration counter = WIDTH-1, go to RUN (or to DONE directly if divisor == 0).
- IDLE/DONE + start=0: DONE → IDLE; IDLE stays.
- RUN, each cycle: shift {partial remainder, dividend register} left 1; trial = partial remainder − divisor computed as WIDTH+1-bit subtraction; trial non-negative → keep trial, shift in quotient bit 1; else restore, shift in 0. Counter decrements; after counter 0 iteration → DONE.
- start while busy: ignored; operands not re-latched.
- Divide by zero: quotient = all ones, remainder = dividend, div_by_zero = 1.
- quotient, remainder, div_by_zero are registered, update only on entry to DONE, and hold until the next DONE entry.
- Reset values: busy 0, done 0, quotient 0, remainder 0, div_by_zero 0. reset_n low mid-RUN aborts immediately; no done pulse for the aborted operation.

## Timing
- start accepted at edge k → busy = 1 from edge k+1 through the cycle before edge k+WIDTH+1.
- Normal latency: done = 1 for exactly the cycle after edge k+WIDTH+1 (WIDTH=32: 33 cycles); busy = 0 in that cycle.
- Divide-by-zero latency: done after edge k+1; busy never asserts.
- Back-to-back: start high during the done cycle is accepted; the next op's busy rises at the following edge. Max throughput: one op per WIDTH+1 cycles.
- busy and done are never both 1.

## Configuration
- DIV_SIGNED_EN defined: operands are two's complement. Magnitudes are divided unsigned. Quotient is negated if operand signs differ, truncating toward zero. Remainder takes the dividend's sign. Sign fix-up happens on the RUN→DONE transition and adds no cycles. Overflow case most-negative ÷ −1 gives quotient = most-negative (0x80000000) and remainder 0. Divide by zero gives quotient all ones and remainder = dividend.
- DIV_SIGNED_EN undefined: unsigned only; no sign logic is synthesized.

## Test plan
- 100 ÷ 7 (start at edge 0) → done at cycle 33, quotient 14, remainder 2, div_by_zero 0.
- 0xFFFFFFFF ÷ 1, then 0x12345678 ÷ 0xFFFFFFFF (unsigned) → q 0xFFFFFFFF r 0; then q 0 r 0x12345678.
- 55 ÷ 0 → done one cycle after start, busy never high, quotient 0xFFFFFFFF, remainder 55, div_by_zero 1. The next valid op clears div_by_zero.
- start pulses with new operands at cycles 5 and 20 of a busy op → ignored; original result delivered at cycle 33. A start during the done cycle is accepted and its result appears 33 cycles later.
- reset_n low at cycle 10 of an op → all outputs 0 asynchronously, no done pulse. A new op after release completes correctly.
- With DIV_SIGNED_EN: −7 ÷ 2 → q −3 (0xFFFFFFFD), r −1. 7 ÷ −2 → q −3, r 1. 0x80000000 ÷ −1 → q 0x80000000, r 0.

Source files
------------

// File: rtl/seq_divider_32bit.sv
// Multi-cycle restoring divider: one trial subtraction per clock, start/done handshake.
// Optional `DIV_SIGNED_EN selects two's-complement operands (truncating division).
module seq_divider_32bit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam int              CW   = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] rem_q;      // partial remainder
  logic [WIDTH-1:0] dvd_q;      // dividend bits shift out, quotient bits shift in
  logic [WIDTH-1:0] divisor_q;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic             q_bit;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quo_next;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;
  logic [WIDTH-1:0] dividend_mag;
  logic [WIDTH-1:0] divisor_mag;

`ifdef DIV_SIGNED_EN
  logic neg_q;
  logic neg_r;
`endif

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    shifted  = {rem_q, dvd_q[WIDTH-1]};
    diff     = shifted - {1'b0, divisor_q};
    // The shifted remainder is below 2*divisor, so bit WIDTH of the difference is a clean borrow.
    q_bit    = ~diff[WIDTH];
    rem_next = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    quo_next = {dvd_q[WIDTH-2:0], q_bit};
`ifdef DIV_SIGNED_EN
    dividend_mag = dividend[WIDTH-1] ? -dividend : dividend;
    divisor_mag  = divisor[WIDTH-1]  ? -divisor  : divisor;
    quo_fix      = neg_q ? -quo_next : quo_next;
    rem_fix      = neg_r ? -rem_next : rem_next;
`else
    dividend_mag = dividend;
    divisor_mag  = divisor;
    quo_fix      = quo_next;
    rem_fix      = rem_next;
`endif
  end

  // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      count       <= '0;
      rem_q       <= '0;
      dvd_q       <= '0;
      divisor_q   <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
`ifdef DIV_SIGNED_EN
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            if (divisor == '0) begin
              state       <= DONE;
              done        <= 1'b1;
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end else begin
              state     <= RUN;
              busy      <= 1'b1;
              count     <= LAST;
              rem_q     <= '0;
              dvd_q     <= dividend_mag;
              divisor_q <= divisor_mag;
`ifdef DIV_SIGNED_EN
              neg_q     <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
              neg_r     <= dividend[WIDTH-1];
`endif
            end
          end else begin
            state <= IDLE;
          end
        end

        RUN: begin
          rem_q <= rem_next;
          dvd_q <= quo_next;
          count <= count - CW'(1);
          if (count == '0) begin
            // Final iteration: results (with any sign fix-up) land directly in the output registers.
            state       <= DONE;
            busy        <= 1'b0;
            done        <= 1'b1;
            quotient    <= quo_fix;
            remainder   <= rem_fix;
            div_by_zero <= 1'b0;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider_32bit.sv
// Table-driven bench for seq_divider_32bit plus hand sequences for ignored starts,
// back-to-back issue and asynchronous abort.
module tb_seq_divider_32bit;

  localparam int LAT = 33;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        start;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
  } vec_t;

  vec_t vecs[$];

  seq_divider_32bit #(.WIDTH(32)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  task automatic add(input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] q, input logic [31:0] r, input logic dz);
    vec_t v;
    v.a = a; v.b = b; v.q = q; v.r = r; v.dz = dz;
    vecs.push_back(v);
  endtask

  task automatic drive_start(input logic [31:0] a, input logic [31:0] b);
    @(posedge clock);
    #1;
    start    = 1'b1;
    dividend = a;
    divisor  = b;
  endtask

  // Counts edges from the one that samples start; optional start pulses at cycles p1/p2.
  // Returns at the falling edge inside the done cycle (or after the cycle budget).
  task automatic track(input int lat, input int p1, input int p2, input string tag);
    int done_at  = -1;
    int busy_cnt = 0;
    int both     = 0;
    for (int n = 1; n <= lat + 8 && done_at < 0; n++) begin
      @(posedge clock);
      #1;
      start = (n == p1) || (n == p2);
      if (start) begin
        dividend = 32'd9;
        divisor  = 32'd3;
      end
      @(negedge clock);
      if (busy) busy_cnt++;
      if (busy && done) both++;
      if (done) done_at = n;
    end
    check({tag, " done cycle"}, 32'(done_at), 32'(lat));
    check({tag, " busy cycles"}, 32'(busy_cnt), 32'(lat - 1));
    check({tag, " busy&done overlap"}, 32'(both), 32'd0);
  endtask

  task automatic check_result(input string tag, input logic [31:0] q, input logic [31:0] r,
                              input logic dz);
    check({tag, " quotient"}, quotient, q);
    check({tag, " remainder"}, remainder, r);
    check({tag, " div_by_zero"}, 32'(div_by_zero), 32'(dz));
  endtask

  initial begin
    int stuck_done;

    reset_n  = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    #1;
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check_result("reset", 32'd0, 32'd0, 1'b0);
    @(negedge clock);
    reset_n = 1'b1;

    add(32'd100,        32'd7,          32'd14,         32'd2,          1'b0);
    add(32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          1'b0);
    add(32'd55,         32'd0,          32'hFFFF_FFFF,  32'd55,         1'b1);
    add(32'd1000,       32'd10,         32'd100,        32'd0,          1'b0);
    add(32'd0,          32'd5,          32'd0,          32'd0,          1'b0);
    add(32'd5,          32'd5,          32'd1,          32'd0,          1'b0);
    add(32'd3,          32'd5,          32'd0,          32'd3,          1'b0);
    add(32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          32'd0,          1'b0);
    add(32'd123456789,  32'd1000,       32'd123456,     32'd789,        1'b0);
`ifdef DIV_SIGNED_EN
    add(32'h1234_5678,  32'hFFFF_FFFF,  32'hEDCB_A988,  32'd0,          1'b0);
    add(32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0);
    add(32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          1'b0);
    add(32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b0);
    add(32'h8000_0000,  32'd2,          32'hC000_0000,  32'd0,          1'b0);
    add(32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFFF,  32'hFFFF_FFF9,  1'b1);
`else
    add(32'h1234_5678,  32'hFFFF_FFFF,  32'd0,          32'h1234_5678,  1'b0);
    add(32'h8000_0000,  32'd2,          32'h4000_0000,  32'd0,          1'b0);
    add(32'hDEAD_BEEF,  32'h10,         32'h0DEA_DBEE,  32'hF,          1'b0);
`endif
    add(32'd42,         32'd1,          32'd42,         32'd0,          1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      drive_start(vecs[i].a, vecs[i].b);
      track(vecs[i].dz ? 1 : LAT, 0, 0, tag);
      check_result(tag, vecs[i].q, vecs[i].r, vecs[i].dz);
      @(negedge clock);
      check({tag, " done drops"}, 32'(done), 32'd0);
      check({tag, " quotient holds"}, quotient, vecs[i].q);
    end

    // Starts while busy are ignored; a start in the done cycle is accepted.
    drive_start(32'd100, 32'd7);
    track(LAT, 5, 20, "ignored starts");
    check_result("ignored starts", 32'd14, 32'd2, 1'b0);
    start    = 1'b1;
    dividend = 32'h0000_FFFF;
    divisor  = 32'h0000_0100;
    track(LAT, 0, 0, "back-to-back");
    check_result("back-to-back", 32'h0000_00FF, 32'h0000_00FF, 1'b0);

    // Asynchronous abort mid-operation.
    drive_start(32'd100, 32'd7);
    @(posedge clock);
    #1 start = 1'b0;
    repeat (9) @(posedge clock);
    #2 reset_n = 1'b0;
    #1;
    check("abort busy", 32'(busy), 32'd0);
    check("abort done", 32'(done), 32'd0);
    check_result("abort", 32'd0, 32'd0, 1'b0);
    stuck_done = 0;
    repeat (3) begin
      @(negedge clock);
      if (done || busy) stuck_done++;
    end
    check("abort quiet in reset", 32'(stuck_done), 32'd0);
    reset_n = 1'b1;
    stuck_done = 0;
    repeat (LAT + 3) begin
      @(negedge clock);
      if (done || busy) stuck_done++;
    end
    check("no done for aborted op", 32'(stuck_done), 32'd0);
    drive_start(32'd1000, 32'd10);
    track(LAT, 0, 0, "post reset");
    check_result("post reset", 32'd100, 32'd0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
